// File: rtl/uart_eth_tx_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_eth_tx_loader
// Brief    : Packs length-prefixed UART frames into 32-bit big-endian words,
//            loads them into an ethernet Tx buffer and triggers transmission.
// Revision : 1.0 - initial release
// ============================================================================
module uart_eth_tx_loader #(
    parameter int          MAX_LEN = 1536,
    parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
    input  logic        clk_100_mhz,
    input  logic        rst_n,
    input  logic        uart_rdy,
    input  logic [7:0]  uart_dout,
    output logic        uart_rdy_clr,
    output logic [31:0] tx_data_in,
    output logic        tx_valid,
    input  logic        tx_ready_to_write,
    input  logic        tx_ready_to_send,
    output logic        tx_send,
    input  logic        tx_done,
    output logic        busy,
    output logic        frame_err,
    output logic [15:0] frames_sent
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HDR_LO    = 3'd1;
    localparam logic [2:0] S_PAYLOAD   = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_WAIT_SEND = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;

    localparam logic [15:0] c_max_len = 16'(MAX_LEN);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        r_rdy_clr;
    logic [15:0] r_len;
    logic [15:0] r_byte_cnt;
    logic [31:0] r_word;
    logic [23:0] r_to_cnt;
    logic        r_frame_err;
    logic        r_tx_send;
    logic [15:0] r_frames_sent;

    logic        w_rx_state;
    logic        w_take;
    logic [15:0] w_len_hdr;
    logic        w_len_bad;
    logic        w_timed_state;
    logic        w_timeout;
    logic [15:0] w_cnt_inc;
    logic        w_word_done;

    // A byte is taken only once the previous consume handshake has closed.
    assign w_rx_state    = (r_state == S_IDLE) || (r_state == S_HDR_LO) || (r_state == S_PAYLOAD);
    assign w_take        = w_rx_state && uart_rdy && !r_rdy_clr;
    assign w_len_hdr     = {r_len[15:8], uart_dout};
    assign w_len_bad     = (w_len_hdr == 16'd0) || (w_len_hdr > c_max_len);
    assign w_timed_state = (r_state == S_HDR_LO) || (r_state == S_PAYLOAD);
    assign w_timeout     = w_timed_state && !w_take && (r_to_cnt == TIMEOUT);
    assign w_cnt_inc     = r_byte_cnt + 16'd1;
    assign w_word_done   = (r_byte_cnt[1:0] == 2'd3) || (w_cnt_inc == r_len);

    always_ff @(posedge clk_100_mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take) w_next = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (w_take)         w_next = w_len_bad ? S_IDLE : S_PAYLOAD;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_PAYLOAD: begin
                if (w_take && w_word_done) w_next = S_WRITE;
                else if (w_timeout)        w_next = S_IDLE;
            end
            S_WRITE: begin
                if (tx_ready_to_write) w_next = (r_byte_cnt < r_len) ? S_PAYLOAD : S_WAIT_SEND;
            end
            S_WAIT_SEND: begin
                if (tx_ready_to_send) w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tx_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        tx_valid = (r_state == S_WRITE);
    end

    always_ff @(posedge clk_100_mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_clr     <= 1'b0;
            r_len         <= 16'd0;
            r_byte_cnt    <= 16'd0;
            r_word        <= 32'd0;
            r_to_cnt      <= 24'd0;
            r_frame_err   <= 1'b0;
            r_tx_send     <= 1'b0;
            r_frames_sent <= 16'd0;
        end else begin
            if (w_take)                r_rdy_clr <= 1'b1;
            else if (!uart_rdy)        r_rdy_clr <= 1'b0;

            if (w_take || !w_timed_state) r_to_cnt <= 24'd0;
            else                          r_to_cnt <= r_to_cnt + 24'd1;

            r_frame_err <= (r_state == S_HDR_LO && w_take && w_len_bad) || w_timeout;
            r_tx_send   <= (r_state == S_WAIT_SEND) && tx_ready_to_send;

            if (r_state == S_WAIT_DONE && tx_done) r_frames_sent <= r_frames_sent + 16'd1;

            if (w_take) begin
                case (r_state)
                    S_IDLE: r_len <= {uart_dout, 8'h00};
                    S_HDR_LO: begin
                        r_len[7:0] <= uart_dout;
                        r_byte_cnt <= 16'd0;
                        r_word     <= 32'd0;
                    end
                    S_PAYLOAD: begin
                        r_byte_cnt <= w_cnt_inc;
                        // Lane 0 restarts the word so a short tail stays zero-padded.
                        case (r_byte_cnt[1:0])
                            2'd0:    r_word        <= {uart_dout, 24'h000000};
                            2'd1:    r_word[23:16] <= uart_dout;
                            2'd2:    r_word[15:8]  <= uart_dout;
                            default: r_word[7:0]   <= uart_dout;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign uart_rdy_clr = r_rdy_clr;
    assign tx_data_in   = r_word;
    assign tx_send      = r_tx_send;
    assign frame_err    = r_frame_err;
    assign frames_sent  = r_frames_sent;

endmodule
`default_nettype wire
